regfile_mp: RTL and testbench

Parametrised multi-port register file for the datapath. It is the successor to the fixed 8×8, 2R/1W register file. It adds configurable width, depth and port counts, with deterministic write-port priority and a per-register busy scoreboard for tracking in-flight results. An optional same-cycle write-to-read bypass is also available. It sits between decode (read addresses, busy marking) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefNumRegs = 8;
  localparam int unsigned DefNumRd   = 2;
  localparam int unsigned DefNumWr   = 2;

  // Address width for a register count; at least one bit.
  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter int unsigned NUM_WR   = DefNumWr
);

  localparam int unsigned AW = addr_w(NUM_REGS);

  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     busy_set;
  logic [AW-1:0]            busy_addr;
  logic                     wr_conflict;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, busy_set, busy_addr,
    input  rd_data, rd_busy, wr_conflict
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, busy_set, busy_addr,
    output rd_data, rd_busy, wr_conflict
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: writes clear, busy_set sets, set wins on a tie.
// With ZERO_REG=1 register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned NUM_WR   = DefNumWr,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned AW      = addr_w(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 busy_set,
  input  logic [AW-1:0]        busy_addr,
  output logic [NUM_REGS-1:0]  busy
);

  logic [NUM_REGS-1:0] busy_d, busy_q;

  // Next busy state: clears first, then the set so a new producer supersedes.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (wr_en[p]) busy_d[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (busy_set) busy_d[busy_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with highest-port-wins write priority,
// registered write-conflict flag and busy scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter int unsigned NUM_WR   = DefNumWr,
  parameter int unsigned ZERO_REG = 0
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned AW = addr_w(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_d, mem_q;
  logic [NUM_WR-1:0]               wr_eff;
  logic                            conflict_d, conflict_q;
  logic [NUM_REGS-1:0]             busy;
  logic [NUM_RD*DATA_W-1:0]        rd_data_c;
  logic [NUM_RD-1:0]               rd_busy_c;

  // Effective write enables: register 0 is read-only when ZERO_REG is set.
  always_comb begin
    wr_eff = bus.wr_en;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if ((ZERO_REG != 0) && (bus.wr_addr[p*AW +: AW] == '0)) wr_eff[p] = 1'b0;
    end
  end

  // Write arbitration: later (higher) ports overwrite earlier ones.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (wr_eff[p]) mem_d[bus.wr_addr[p*AW +: AW]] = bus.wr_data[p*DATA_W +: DATA_W];
    end
  end

  // Conflict detection: any pair of effective ports on the same address.
  always_comb begin
    conflict_d = 1'b0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      for (int unsigned q = p + 1; q < NUM_WR; q++) begin
        if (wr_eff[p] && wr_eff[q] &&
            (bus.wr_addr[p*AW +: AW] == bus.wr_addr[q*AW +: AW])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Storage and conflict flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      conflict_q <= conflict_d;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .busy_set  (bus.busy_set),
    .busy_addr (bus.busy_addr),
    .busy      (busy)
  );

  // Read muxes; register 0 never gets written under ZERO_REG so it reads 0.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_data_c[r*DATA_W +: DATA_W] = mem_q[bus.rd_addr[r*AW +: AW]];
      rd_busy_c[r]                  = busy[bus.rd_addr[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_eff[p] && (bus.wr_addr[p*AW +: AW] == bus.rd_addr[r*AW +: AW])) begin
          rd_data_c[r*DATA_W +: DATA_W] = bus.wr_data[p*DATA_W +: DATA_W];
          if (!(bus.busy_set && (bus.busy_addr == bus.rd_addr[r*AW +: AW]))) begin
            rd_busy_c[r] = 1'b0;
          end
        end
      end
`endif
    end
  end

  assign bus.rd_data     = rd_data_c;
  assign bus.rd_busy     = rd_busy_c;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: table of write/read vectors through a scoreboard queue,
// plus hand sequences for bypass timing, ZERO_REG and mid-burst reset.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(8), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2)) mif ();
  regfile_mp_if #(.DATA_W(8), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2)) zif ();

  // The ZERO_REG=1 instance sees exactly the same stimulus.
  assign zif.wr_en     = mif.wr_en;
  assign zif.wr_addr   = mif.wr_addr;
  assign zif.wr_data   = mif.wr_data;
  assign zif.rd_addr   = mif.rd_addr;
  assign zif.busy_set  = mif.busy_set;
  assign zif.busy_addr = mif.busy_addr;

  regfile_mp #(.DATA_W(8), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  regfile_mp #(.DATA_W(8), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_zero (
    .clk (clk),
    .rst (rst),
    .bus (zif.slave)
  );

  typedef struct {
    logic [1:0] we;
    logic [2:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic       bs;
    logic [2:0] ba;
    logic [2:0] ra0, ra1;
    logic [7:0] ed0, ed1;
    logic [1:0] eb;
    logic       ec;
  } vec_t;

  typedef struct {
    logic [7:0] ed0, ed1;
    logic [1:0] eb;
    logic       ec;
  } exp_t;

  localparam int NumVec = 15;
  vec_t vecs [NumVec];
  exp_t sb_q [$];

  function automatic vec_t mk(input int we, input int wa0, input int wd0, input int wa1,
                              input int wd1, input int bs, input int ba, input int ra0,
                              input int ra1, input int ed0, input int ed1, input int eb,
                              input int ec);
    vec_t v;
    v.we  = 2'(we);
    v.wa0 = 3'(wa0);
    v.wd0 = 8'(wd0);
    v.wa1 = 3'(wa1);
    v.wd1 = 8'(wd1);
    v.bs  = 1'(bs);
    v.ba  = 3'(ba);
    v.ra0 = 3'(ra0);
    v.ra1 = 3'(ra1);
    v.ed0 = 8'(ed0);
    v.ed1 = 8'(ed1);
    v.eb  = 2'(eb);
    v.ec  = 1'(ec);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [2:0] wa0, input logic [7:0] wd0,
                       input logic [2:0] wa1, input logic [7:0] wd1, input logic bs,
                       input logic [2:0] ba, input logic [2:0] ra0, input logic [2:0] ra1);
    mif.wr_en     = we;
    mif.wr_addr   = {wa1, wa0};
    mif.wr_data   = {wd1, wd0};
    mif.busy_set  = bs;
    mif.busy_addr = ba;
    mif.rd_addr   = {ra1, ra0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = mk('b11, 3, 'hA5, 5, 'h3C, 0, 0, 3, 5, 'hA5, 'h3C, 'b00, 0);
    vecs[1]  = mk('b11, 2, 'h11, 2, 'h22, 0, 0, 2, 3, 'h22, 'hA5, 'b00, 1);
    vecs[2]  = mk('b00, 0, 0,    0, 0,    0, 0, 2, 5, 'h22, 'h3C, 'b00, 0);
    vecs[3]  = mk('b00, 0, 0,    0, 0,    1, 4, 4, 4, 'h00, 'h00, 'b11, 0);
    vecs[4]  = mk('b00, 0, 0,    0, 0,    0, 0, 4, 3, 'h00, 'hA5, 'b01, 0);
    vecs[5]  = mk('b01, 4, 'h7E, 0, 0,    1, 4, 4, 4, 'h7E, 'h7E, 'b11, 0);
    vecs[6]  = mk('b10, 0, 0,    4, 'h81, 0, 0, 4, 2, 'h81, 'h22, 'b00, 0);
    vecs[7]  = mk('b11, 6, 'h01, 6, 'h02, 0, 0, 6, 4, 'h02, 'h81, 'b00, 1);
    vecs[8]  = mk('b11, 6, 'h03, 6, 'h04, 0, 0, 6, 4, 'h04, 'h81, 'b00, 1);
    vecs[9]  = mk('b11, 7, 'h55, 1, 'h66, 0, 0, 7, 1, 'h55, 'h66, 'b00, 0);
    vecs[10] = mk('b01, 7, 'h99, 0, 0,    1, 1, 1, 7, 'h66, 'h99, 'b01, 0);
    vecs[11] = mk('b11, 0, 'hEE, 1, 'h77, 0, 0, 0, 1, 'hEE, 'h77, 'b00, 0);
    vecs[12] = mk('b10, 5, 'hAA, 5, 'hBB, 0, 0, 5, 0, 'hBB, 'hEE, 'b00, 0);
    vecs[13] = mk('b00, 0, 0,    0, 0,    1, 3, 3, 3, 'hA5, 'hA5, 'b11, 0);
    vecs[14] = mk('b01, 2, 'h12, 0, 0,    0, 0, 3, 2, 'hA5, 'h12, 'b01, 0);

    // Reads during and just after reset: everything zero.
    repeat (2) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      mif.rd_addr = {3'(7 - a), 3'(a)};
      #1;
      check($sformatf("rst_data_r%0d", a), 32'(mif.rd_data), 0);
      check($sformatf("rst_busy_r%0d", a), 32'(mif.rd_busy), 0);
    end
    check("rst_conflict", 32'(mif.wr_conflict), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 8; a += 3) begin
      mif.rd_addr = {3'(7 - a), 3'(a)};
      #1;
      check($sformatf("post_rst_data_r%0d", a), 32'(mif.rd_data), 0);
    end

    // Table vectors: expectation queued at drive, checked after the edge.
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
            vecs[i].bs, vecs[i].ba, vecs[i].ra0, vecs[i].ra1);
      sb_q.push_back('{ed0: vecs[i].ed0, ed1: vecs[i].ed1, eb: vecs[i].eb, ec: vecs[i].ec});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d_sb_empty", i), 1, 0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_rd0", i), 32'(mif.rd_data[7:0]), 32'(e.ed0));
        check($sformatf("v%0d_rd1", i), 32'(mif.rd_data[15:8]), 32'(e.ed1));
        check($sformatf("v%0d_busy", i), 32'(mif.rd_busy), 32'(e.eb));
        check($sformatf("v%0d_conflict", i), 32'(mif.wr_conflict), 32'(e.ec));
      end
    end

    // Same-cycle read of a register being written (r6 holds 0x04).
    @(negedge clk);
    drive(2'b01, 6, 8'h5A, 0, 0, 0, 0, 6, 2);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", 32'(mif.rd_data[7:0]), 32'h5A);
`else
    check("no_bypass_same_cycle", 32'(mif.rd_data[7:0]), 32'h04);
`endif
    @(posedge clk);
    #1;
    check("write_next_cycle", 32'(mif.rd_data[7:0]), 32'h5A);

    // Both ports write r0 with busy_set r0: only ZERO_REG=0 honours it.
    @(negedge clk);
    drive(2'b11, 0, 8'hFF, 0, 8'h0F, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    check("r0_main_data", 32'(mif.rd_data[7:0]), 32'h0F);
    check("r0_main_busy", 32'(mif.rd_busy[0]), 1);
    check("r0_main_conflict", 32'(mif.wr_conflict), 1);
    check("r0_zero_data", 32'(zif.rd_data[7:0]), 0);
    check("r0_zero_busy", 32'(zif.rd_busy[0]), 0);
    check("r0_zero_conflict", 32'(zif.wr_conflict), 0);
    check("r1_zero_data", 32'(zif.rd_data[15:8]), 32'h77);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check("conflict_drops", 32'(mif.wr_conflict), 0);

    // Mid-burst reset with a conflicting write to r3 and busy_set r5 pending.
    @(negedge clk);
    drive(2'b11, 3, 8'hC1, 3, 8'hC2, 1, 5, 3, 5);
    @(posedge clk);
    #1;
    check("pre_rst_r3", 32'(mif.rd_data[7:0]), 32'hC2);
    check("pre_rst_r5", 32'(mif.rd_data[15:8]), 32'hBB);
    check("pre_rst_busy", 32'(mif.rd_busy), 32'b10);
    check("pre_rst_conflict", 32'(mif.wr_conflict), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data", 32'(mif.rd_data), 0);
    check("async_rst_busy", 32'(mif.rd_busy), 0);
    check("async_rst_conflict", 32'(mif.wr_conflict), 0);
    @(posedge clk);
    #1;
    check("rst_held_data", 32'(mif.rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_data", 32'(mif.rd_data), 0);
    check("rst_release_busy", 32'(mif.rd_busy), 0);
    check("rst_release_conflict", 32'(mif.wr_conflict), 0);
    @(posedge clk);
    #1;
    check("first_write_r3", 32'(mif.rd_data[7:0]), 32'hC2);
    check("first_write_busy", 32'(mif.rd_busy), 32'b10);
    check("first_write_conflict", 32'(mif.wr_conflict), 1);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
